// File: rtl/led_pkg.sv
// led_pkg: definitions shared by the LED row-scan controller and its frame store.
//   NUM_LINES    number of display lines driven through the 5-to-32 decoder
//   LINE_AW      width of a line address
//   scan_state_t scan FSM states
//   cnt_width()  width of a counter that must hold 0 .. max(a,b)-1 without truncation
package led_pkg;

  localparam int NUM_LINES = 32;
  localparam int LINE_AW   = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BLANK   = 2'd1,
    DISPLAY = 2'd2
  } scan_state_t;

  // A single-cycle phase still needs a 1-bit counter.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/led_frame_buf.sv
// led_frame_buf: double-buffered 2 x NUM_LINES x COL_W column-pattern store.
//   clk, rst_n  clock and asynchronous active-low reset (clears both buffers)
//   front_sel   selects the buffer being displayed; the other one is the back buffer
//   wr_en       write strobe; writes always land in the back buffer
//   wr_addr     line index of the write
//   wr_data     column pattern to write
//   rd_addr     line index for the front-buffer read
//   rd_data     front-buffer pattern at rd_addr (combinational read)
module led_frame_buf
  import led_pkg::*;
#(
  parameter int COL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               front_sel,
  input  logic               wr_en,
  input  logic [LINE_AW-1:0] wr_addr,
  input  logic [COL_W-1:0]   wr_data,
  input  logic [LINE_AW-1:0] rd_addr,
  output logic [COL_W-1:0]   rd_data
);

  logic [COL_W-1:0] buf0_reg [NUM_LINES];
  logic [COL_W-1:0] buf1_reg [NUM_LINES];

  // front_sel is the pre-swap value on a swap edge, so a coincident write
  // lands in the buffer that is about to become the front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        buf0_reg[i] <= '0;
        buf1_reg[i] <= '0;
      end
    end else if (wr_en) begin
      if (front_sel) begin
        buf0_reg[wr_addr] <= wr_data;
      end else begin
        buf1_reg[wr_addr] <= wr_data;
      end
    end
  end

  assign rd_data = front_sel ? buf1_reg[rd_addr] : buf0_reg[rd_addr];

endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: row-scan controller for a 5-to-32 decoded LED display.
// Each line is blanked for BLANK_CYCLES, then lit for CLK_DIV cycles, and
// the scan walks lines 0..31 continuously while run=1.
//   clk, rst_n   clock and asynchronous active-low reset
//   run          1 = scan, 0 = stop immediately and blank
//   line_addr    decoder address (registered)
//   line_en      decoder enable (registered)
//   col_data     column pattern of line_addr, valid while line_en=1
//   frame_start  1-cycle pulse on the first lit cycle of line 0
//   wr_en/wr_addr/wr_data  host write into the back buffer
//   swap_req     pulse requesting a back/front swap
//   swap_ack     1-cycle pulse when the swap takes effect
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int COL_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [LINE_AW-1:0] line_addr,
  output logic               line_en,
  output logic [COL_W-1:0]   col_data,
  output logic               frame_start,
  input  logic               wr_en,
  input  logic [LINE_AW-1:0] wr_addr,
  input  logic [COL_W-1:0]   wr_data,
  input  logic               swap_req,
  output logic               swap_ack
);

  localparam int                 CNT_W      = cnt_width(CLK_DIV, BLANK_CYCLES);
  localparam logic [CNT_W-1:0]   DISP_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [LINE_AW-1:0] LAST_LINE  = LINE_AW'(NUM_LINES - 1);

  scan_state_t        state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [LINE_AW-1:0] line_addr_reg, line_addr_next;
  logic               line_en_reg, line_en_next;
  logic [COL_W-1:0]   col_data_reg, col_data_next;
  logic               frame_start_reg, frame_start_next;
  logic               swap_ack_reg, swap_ack_next;
  logic               front_sel_reg, front_sel_next;
  logic               swap_pending_reg, swap_pending_next;
  logic               frame_end;
  logic               do_swap;
  logic [COL_W-1:0]   front_rd_data;

  led_frame_buf #(
    .COL_W(COL_W)
  ) u_frame_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .front_sel(front_sel_reg),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (line_addr_reg),
    .rd_data  (front_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      line_addr_reg    <= '0;
      line_en_reg      <= 1'b0;
      col_data_reg     <= '0;
      frame_start_reg  <= 1'b0;
      swap_ack_reg     <= 1'b0;
      front_sel_reg    <= 1'b0;
      swap_pending_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      line_addr_reg    <= line_addr_next;
      line_en_reg      <= line_en_next;
      col_data_reg     <= col_data_next;
      frame_start_reg  <= frame_start_next;
      swap_ack_reg     <= swap_ack_next;
      front_sel_reg    <= front_sel_next;
      swap_pending_reg <= swap_pending_next;
    end
  end

  // Outputs are computed one edge ahead so that every port is a flop.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    line_addr_next    = line_addr_reg;
    line_en_next      = line_en_reg;
    col_data_next     = col_data_reg;
    frame_start_next  = 1'b0;
    swap_ack_next     = 1'b0;
    front_sel_next    = front_sel_reg;
    swap_pending_next = swap_pending_reg;
    frame_end         = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next       = '0;
        line_addr_next = '0;
        line_en_next   = 1'b0;
        if (run) begin
          state_next = BLANK;
        end
      end
      BLANK: begin
        if (!run) begin
          state_next     = IDLE;
          cnt_next       = '0;
          line_addr_next = '0;
          line_en_next   = 1'b0;
          col_data_next  = '0;
        end else if (cnt_reg == BLANK_LAST) begin
          // Latch the pattern now so it is stable on the first lit cycle.
          state_next       = DISPLAY;
          cnt_next         = '0;
          line_en_next     = 1'b1;
          col_data_next    = front_rd_data;
          frame_start_next = (line_addr_reg == '0);
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DISPLAY: begin
        if (!run) begin
          state_next     = IDLE;
          cnt_next       = '0;
          line_addr_next = '0;
          line_en_next   = 1'b0;
          col_data_next  = '0;
        end else if (cnt_reg == DISP_LAST) begin
          state_next     = BLANK;
          cnt_next       = '0;
          line_en_next   = 1'b0;
          line_addr_next = line_addr_reg + LINE_AW'(1);
          frame_end      = (line_addr_reg == LAST_LINE);
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next     = IDLE;
        cnt_next       = '0;
        line_addr_next = '0;
        line_en_next   = 1'b0;
      end
    endcase

    // Swaps only happen between frames (or at once while idle), so a frame
    // never mixes patterns from both buffers. A request arriving on the swap
    // edge itself is absorbed by the swap in progress.
    do_swap = swap_pending_reg && ((state_reg == IDLE) || frame_end);
    if (do_swap) begin
      front_sel_next    = ~front_sel_reg;
      swap_pending_next = 1'b0;
      swap_ack_next     = 1'b1;
    end else if (swap_req) begin
      swap_pending_next = 1'b1;
    end
  end

  assign line_addr   = line_addr_reg;
  assign line_en     = line_en_reg;
  assign col_data    = col_data_reg;
  assign frame_start = frame_start_reg;
  assign swap_ack    = swap_ack_reg;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: self-checking bench for led_scan_ctrl (CLK_DIV=4, BLANK_CYCLES=2).
// A positional reference model predicts every cycle's outputs into a queue
// that is popped and compared on the falling edge; a start-up table and a few
// hand-written sequences cover the corner cases.
module tb_led_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       swap_req = 1'b0;
  logic [4:0] line_addr;
  logic       line_en;
  logic [7:0] col_data;
  logic       frame_start;
  logic       swap_ack;

  led_scan_ctrl #(
    .CLK_DIV(4),
    .BLANK_CYCLES(2),
    .COL_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .line_addr  (line_addr),
    .line_en    (line_en),
    .col_data   (col_data),
    .frame_start(frame_start),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack)
  );

  always #5 clk = ~clk;

  localparam int LINE_P  = 6;          // BLANK_CYCLES + CLK_DIV
  localparam int FRAME_P = 32 * LINE_P;

  typedef struct {
    logic       en;
    logic [4:0] addr;
    logic       fs;
    logic       ack;
    logic       col_v;
    logic [7:0] col;
  } exp_t;

  typedef struct {
    logic       run;
    logic       en;
    logic [4:0] addr;
    logic       fs;
  } start_vec_t;

  exp_t       sb_q[$];
  start_vec_t start_tbl[9];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  logic [7:0] mbuf[2][32];
  bit         mfront = 1'b0;
  bit         mpend  = 1'b0;
  bit         mact   = 1'b0;
  bit         mack   = 1'b0;
  int         mp     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model update for one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    bit doswap;
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int l = 0; l < 32; l++) mbuf[b][l] = 8'h00;
      mfront = 0; mpend = 0; mact = 0; mp = 0; mack = 0;
    end else begin
      doswap = mpend && (!mact || ((mp % FRAME_P) == FRAME_P - 1 && run));
      if (wr_en) mbuf[!mfront][wr_addr] = wr_data;
      mack = 0;
      if (doswap) begin
        mfront = !mfront; mpend = 0; mack = 1;
      end else if (swap_req) begin
        mpend = 1;
      end
      if (mact && !run) mact = 0;
      else if (!mact && run) begin mact = 1; mp = 0; end
      else if (mact) mp++;
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_edge();
    if (!rst_n) begin
      e = '{en: 1'b0, addr: 5'd0, fs: 1'b0, ack: 1'b0, col_v: 1'b1, col: 8'h00};
    end else begin
      e.en    = mact && ((mp % LINE_P) >= 2);
      e.addr  = mact ? 5'((mp / LINE_P) % 32) : 5'd0;
      e.fs    = e.en && ((mp % LINE_P) == 2) && (e.addr == 5'd0);
      e.ack   = mack;
      e.col_v = e.en;
      e.col   = mbuf[mfront][e.addr];
    end
    sb_q.push_back(e);
    @(negedge clk);
    cyc++;
    e = sb_q.pop_front();
    chk("sb_ctrl", {line_en, line_addr, frame_start, swap_ack}, {e.en, e.addr, e.fs, e.ack});
    if (e.col_v) chk("sb_col", col_data, e.col);
  endtask

  task automatic run_start_table(output int fs_cyc);
    fs_cyc = -1;
    for (int i = 0; i < 9; i++) begin
      run = start_tbl[i].run;
      tick();
      chk("start_vec", {line_en, line_addr, frame_start},
          {start_tbl[i].en, start_tbl[i].addr, start_tbl[i].fs});
      if (frame_start === 1'b1) fs_cyc = cyc;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  fs0, fs1, ack_cyc, dummy;
    bit  seen;

    //           run   en    addr   fs
    start_tbl[0] = '{1'b1, 1'b0, 5'd0, 1'b0};
    start_tbl[1] = '{1'b1, 1'b0, 5'd0, 1'b0};
    start_tbl[2] = '{1'b1, 1'b1, 5'd0, 1'b1};
    start_tbl[3] = '{1'b1, 1'b1, 5'd0, 1'b0};
    start_tbl[4] = '{1'b1, 1'b1, 5'd0, 1'b0};
    start_tbl[5] = '{1'b1, 1'b1, 5'd0, 1'b0};
    start_tbl[6] = '{1'b1, 1'b0, 5'd1, 1'b0};
    start_tbl[7] = '{1'b1, 1'b0, 5'd1, 1'b0};
    start_tbl[8] = '{1'b1, 1'b1, 5'd1, 1'b0};

    // Reset held, then released with run=0: everything stays quiet.
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();

    // Start-up timing.
    run_start_table(fs0);
    chk("first_fs_seen", (fs0 >= 0), 1);

    // Fill the back buffer; line 5 gets the marker pattern.
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1;
      wr_addr = 5'(i);
      wr_data = (i == 5) ? 8'hA5 : 8'(8'h40 + i);
      tick();
    end
    wr_en = 1'b0;

    // Mid-frame swap request; takes effect at the line-31 exit.
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    seen = 0; ack_cyc = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      tick();
      if (swap_ack === 1'b1) begin seen = 1; ack_cyc = cyc; end
    end
    chk("swap_ack_seen", seen, 1);
    chk("swap_ack_pos", ack_cyc - fs0, FRAME_P - 2);

    seen = 0; fs1 = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (frame_start === 1'b1) begin seen = 1; fs1 = cyc; end
    end
    chk("frame_period", fs1 - fs0, FRAME_P);

    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      if (line_en === 1'b1 && line_addr === 5'd5) seen = 1;
    end
    chk("line5_reached", seen, 1);
    chk("new_front_line5", col_data, 8'hA5);

    // Write to the new back buffer must not disturb the display.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      tick();
      if (line_addr === 5'd6) seen = 1;
    end
    seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      tick();
      if (line_en === 1'b1 && line_addr === 5'd5) seen = 1;
    end
    chk("line5_again", seen, 1);
    chk("front_unchanged", col_data, 8'hA5);

    // Stop during DISPLAY of line 7, then restart.
    seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      tick();
      if (line_en === 1'b1 && line_addr === 5'd7) seen = 1;
    end
    chk("line7_reached", seen, 1);
    run = 1'b0;
    tick();
    chk("stop_blank", {line_en, line_addr}, 6'd0);
    repeat (3) tick();
    run_start_table(dummy);

    // Asynchronous reset mid-DISPLAY with a swap pending.
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("pre_reset_lit", line_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {line_en, line_addr, col_data, frame_start, swap_ack}, 16'd0);
    run = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Buffers cleared and front_sel back at 0: line 5 shows 0.
    run = 1'b1;
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      if (line_en === 1'b1 && line_addr === 5'd5) seen = 1;
    end
    chk("post_reset_line5", seen, 1);
    chk("post_reset_col", col_data, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
Row-scan controller that drives the 5-to-32 line decoder of the LED display. It steps a 5-bit line address through all 32 lines with a programmable dwell time and a blanking gap between lines, and qualifies the decoder with an enable. It presents the column pattern for the active line from a double-buffered frame store that the host writes.

Parameters:
CLK_DIV, 1000, clk cycles each line is lit (DISPLAY dwell); must be >= 1
BLANK_CYCLES, 16, clk cycles line_en is held low between lines (anti-ghosting); must be >= 1
COL_W, 8, column pattern width per line

Ports:
clk  input  1  system clock, the only clock; all logic rising-edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = scan, 0 = stop and blank
line_addr  output  5  line select, connects to decoder address input
line_en  output  1  decoder enable; 1 = selected line lit
col_data  output  COL_W  column pattern for line_addr, valid while line_en=1
frame_start  output  1  1-cycle pulse on the first DISPLAY cycle of line 0
wr_en  input  1  host write strobe to the back buffer
wr_addr  input  5  host line index
wr_data  input  COL_W  host column pattern
swap_req  input  1  1-cycle pulse requesting back/front buffer swap
swap_ack  output  1  1-cycle pulse when the swap takes effect

Behaviour:
- Reset (async, rst_n=0): state=IDLE, line_addr=0, line_en=0, col_data=0, frame_start=0, swap_ack=0, front_sel=0, swap_pending=0, both buffers cleared to 0.
- States: IDLE, BLANK, DISPLAY. All outputs are registered.
- IDLE: line_en=0, line_addr=0. run=1 sampled at edge k gives BLANK from k+1.
- BLANK: lasts BLANK_CYCLES cycles with line_en=0. col_data loads front[line_addr] on the final BLANK cycle, so it is stable for the first DISPLAY cycle. Then DISPLAY.
- DISPLAY: lasts CLK_DIV cycles with line_en=1. On exit, line_addr increments mod 32 (31 wraps to 0), then BLANK.
- Line period = BLANK_CYCLES+CLK_DIV. Frame period = 32 times that.
- frame_start is high for exactly the first DISPLAY cycle of line_addr=0.
- run=0 in BLANK or DISPLAY stops immediately: next cycle state=IDLE, line_en=0, line_addr=0, dwell counter cleared. A restart always begins at line 0 with a full BLANK.
- Writes: wr_en=1 writes wr_data into the back buffer (~front_sel) at wr_addr. The front buffer is never written. A write lands in one cycle.
- Swap: a swap_req pulse sets swap_pending. A swap_req while already pending has no further effect.
  - In BLANK/DISPLAY, a pending swap is applied on the DISPLAY-exit edge of line 31: front_sel toggles, swap_pending clears, and swap_ack pulses 1 cycle concurrently. Line 0 of the next frame shows the new buffer.
  - In IDLE, a pending swap applies on the next edge.
- wr_en coincident with the swap edge: the write goes to the pre-swap back buffer, which becomes the front buffer.
- swap_req coincident with the swap edge of an already-pending swap: that swap completes and the new pulse is ignored.
- Dwell and blank counters are sized to clog2 of the larger parameter; no truncation allowed.

Decomposition:
- Shared package led_pkg: NUM_LINES=32, LINE_AW=5, scan state enum (IDLE/BLANK/DISPLAY).
- Sub-module led_frame_buf: 2x32xCOL_W register file with front_sel, write port to the back buffer, and async read port of the front buffer. led_scan_ctrl holds the FSM, counters and swap logic.

Test Plan:
All tests use CLK_DIV=4, BLANK_CYCLES=2.
- Reset: hold rst_n=0, then release -> every output 0, line_addr=0; nothing toggles while run=0.
- Start: run=1 sampled at edge k -> line_en=0 for k+1..k+2; line_en=1, line_addr=0, frame_start=1 at k+3 only; line_en stays 1 through k+6; line_addr=1 from k+7; line_en=1 again at k+9.
- Wrap: keep run=1 -> line_addr steps 0..31 then 0; the next frame_start comes exactly 192 cycles after the first.
- Swap: before the swap, write back line 5 with 8'hA5 and fire swap_req mid-frame -> col_data unchanged this frame; swap_ack pulses at the line-31 exit; col_data=8'hA5 while line_addr=5 in the next frame; writing line 5 with 8'h3C afterwards does not change the display.
- Stop: run=0 during DISPLAY of line 7 -> next cycle line_en=0, line_addr=0, IDLE; run=1 again -> restarts with line 0 after 2 blank cycles.
- Async reset mid-DISPLAY with a swap pending: rst_n low between clock edges -> outputs zero immediately; after release front_sel=0 and no swap_ack.
